// File: rtl/acc_result_drain.sv
// Result drain for the MAC array: requantizes the four skewed accumulator lanes,
// assembles full rows, buffers them in a small FIFO and streams them out one lane per cycle.
module acc_result_drain #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int N_MACS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    relu_en,
    input  logic [3:0]              shift_amt,
    input  logic signed [ACC_W-1:0] acc_in_0,
    input  logic signed [ACC_W-1:0] acc_in_1,
    input  logic signed [ACC_W-1:0] acc_in_2,
    input  logic signed [ACC_W-1:0] acc_in_3,
    input  logic [N_MACS-1:0]       valid_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic [1:0]              out_lane,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              row_count,
    output logic                    overflow,
    output logic                    busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ROW_W = N_MACS * OUT_W;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // Round half up, arithmetic shift, optional ReLU, saturate; ACC_W+1 bits keeps the rounding add exact.
    function automatic logic [OUT_W-1:0] quantize(
        input logic signed [ACC_W-1:0] acc,
        input logic [3:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] shifted;
        logic [OUT_W-1:0]      res;
        ext = {acc[ACC_W-1], acc};
        rnd = '0;
        if (sh != 4'd0) begin
            rnd = {{ACC_W{1'b0}}, 1'b1} << (sh - 4'd1);
        end
        shifted = (ext + rnd) >>> sh;
        if (relu && shifted[ACC_W]) begin
            res = '0;
        end else if (shifted > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = shifted[OUT_W-1:0];
        end
        return res;
    endfunction

    logic signed [ACC_W-1:0] acc_in [N_MACS];

    logic [OUT_W-1:0]  lane_q [N_MACS];
    logic [OUT_W-1:0]  lane_d [N_MACS];
    logic [N_MACS-1:0] captured_q;
    logic [N_MACS-1:0] captured_d;
    logic [ROW_W-1:0]  row_word;
    logic              row_done;
    logic              recapture;

    logic [ROW_W-1:0]  fifo_mem [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;
    logic [AW:0]       fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              drop;
    logic              pop;
    logic              handshake;

    logic [1:0]        lane_idx_q;
    logic [1:0]        lane_idx_d;
    logic [7:0]        row_count_q;
    logic [7:0]        row_count_d;
    logic              overflow_q;
    logic              overflow_d;
    logic [ROW_W-1:0]  head_row;

    state_t            state_q;
    state_t            state_d;

    assign acc_in[0] = acc_in_0;
    assign acc_in[1] = acc_in_1;
    assign acc_in[2] = acc_in_2;
    assign acc_in[3] = acc_in_3;

    // The pushed row includes lanes captured on the completing edge itself.
    always_comb begin
        captured_d = captured_q | valid_in;
        recapture  = |(captured_q & valid_in);
        row_done   = &captured_d;
        row_word   = '0;
        for (int i = 0; i < N_MACS; i++) begin
            lane_d[i] = valid_in[i] ? quantize(acc_in[i], shift_amt, relu_en) : lane_q[i];
            row_word[i*OUT_W +: OUT_W] = lane_d[i];
        end
        if (row_done) begin
            captured_d = '0;
        end
        if (clear) begin
            captured_d = '0;
            for (int i = 0; i < N_MACS; i++) begin
                lane_d[i] = '0;
            end
        end
    end

    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        handshake  = (state_q == ST_EMIT) && out_ready;
        pop        = handshake && (lane_idx_q == 2'd3);
        push       = row_done && !clear && (!fifo_full || pop);
        drop       = row_done && fifo_full && !pop;

        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        lane_idx_d  = handshake ? lane_idx_q + 2'd1 : lane_idx_q;
        row_count_d = row_count_q + {7'd0, pop};
        overflow_d  = overflow_q || recapture || drop;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            lane_idx_d  = '0;
            row_count_d = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_MACS; i++) begin
                lane_q[i] <= '0;
            end
            captured_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lane_idx_q  <= '0;
            row_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            lane_q      <= lane_d;
            captured_q  <= captured_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lane_idx_q  <= lane_idx_d;
            row_count_q <= row_count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read while the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= row_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Looking at the same-edge push lets a fresh row appear the cycle right after it completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (pop && !push && (fifo_count == {{AW{1'b0}}, 1'b1})) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        head_row  = fifo_mem[rd_ptr_q[AW-1:0]];
        out_valid = (state_q == ST_EMIT);
        out_lane  = lane_idx_q;
        out_last  = out_valid && (lane_idx_q == 2'd3);
        out_data  = '0;
        if (out_valid) begin
            out_data = head_row[lane_idx_q*OUT_W +: OUT_W];
        end
        row_count = row_count_q;
        overflow  = overflow_q;
        busy      = (|captured_q) || !fifo_empty || out_valid;
    end

endmodule

// File: tb/tb_acc_result_drain.sv
// Directed bench for acc_result_drain: a table of single-row quantization vectors
// followed by hand-written sequences for skew, re-capture, clear, reset and backpressure.
module tb_acc_result_drain;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              relu_en;
    logic [3:0]        shift_amt;
    logic [15:0]       acc0;
    logic [15:0]       acc1;
    logic [15:0]       acc2;
    logic [15:0]       acc3;
    logic [3:0]        valid_in;
    logic signed [7:0] out_data;
    logic [1:0]        out_lane;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        row_count;
    logic              overflow;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]        shift;
        logic              relu;
        logic [3:0][15:0]  accs;
        logic [3:0][7:0]   exps;
    } vec_t;

    vec_t vectors [6];

    acc_result_drain #(
        .ACC_W(16), .OUT_W(8), .N_MACS(4), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en), .shift_amt(shift_amt),
        .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
        .valid_in(valid_in), .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .row_count(row_count),
        .overflow(overflow), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0][15:0] pack4(input int a0, input int a1, input int a2, input int a3);
        logic [3:0][15:0] r;
        r[0] = a0[15:0];
        r[1] = a1[15:0];
        r[2] = a2[15:0];
        r[3] = a3[15:0];
        return r;
    endfunction

    function automatic logic [3:0][7:0] exp4(input int e0, input int e1, input int e2, input int e3);
        logic [3:0][7:0] r;
        r[0] = e0[7:0];
        r[1] = e1[7:0];
        r[2] = e2[7:0];
        r[3] = e3[7:0];
        return r;
    endfunction

    function automatic vec_t mkvec(input int sh, input int relu, input logic [3:0][15:0] a,
                                   input logic [3:0][7:0] e);
        vec_t v;
        v.shift = sh[3:0];
        v.relu  = relu[0];
        v.accs  = a;
        v.exps  = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // All driving and sampling happens at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0][15:0] accs,
                                 input logic [3:0] sh, input logic relu);
        valid_in  = valid;
        acc0      = accs[0];
        acc1      = accs[1];
        acc2      = accs[2];
        acc3      = accs[3];
        shift_amt = sh;
        relu_en   = relu;
    endtask

    task automatic drainRow(input logic [3:0][7:0] exps, input string tag);
        for (int l = 0; l < 4; l++) begin
            checkOutput($sformatf("%s lane%0d valid", tag, l), int'(out_valid), 1);
            checkOutput($sformatf("%s lane%0d index", tag, l), int'(out_lane), l);
            checkOutput($sformatf("%s lane%0d data", tag, l), int'(out_data), int'($signed(exps[l])));
            checkOutput($sformatf("%s lane%0d last", tag, l), int'(out_last), (l == 3) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(4'b0000, pack4(0, 0, 0, 0), 4'd0, 1'b0);

        vectors[0] = mkvec(4, 0, pack4('h0140, 'h0018, 'hFFF0, 'h0007), exp4(20, 2, -1, 0));
        vectors[1] = mkvec(0, 0, pack4('h7FFF, 'h8000, -300, 5), exp4(127, -128, -128, 5));
        vectors[2] = mkvec(0, 1, pack4('h7FFF, 'h8000, -300, 5), exp4(127, 0, 0, 5));
        vectors[3] = mkvec(15, 0, pack4('h7FFF, 'h8000, 'h4000, 'h3FFF), exp4(1, -1, 1, 0));
        vectors[4] = mkvec(1, 1, pack4('h00FF, 'hFF01, 'h0003, 'h00FE), exp4(127, 0, 2, 127));
        vectors[5] = mkvec(1, 0, pack4('hFF01, 'hFF00, 'hFEFF, 'h0000), exp4(-127, -128, -128, 0));

        step();
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset out_lane", int'(out_lane), 0);
        checkOutput("reset out_last", int'(out_last), 0);
        checkOutput("reset row_count", int'(row_count), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            applyStimulus(4'b1111, vectors[v].accs, vectors[v].shift, vectors[v].relu);
            step();
            valid_in = 4'b0000;
            drainRow(vectors[v].exps, $sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d idle after", v), int'(out_valid), 0);
            checkOutput($sformatf("vec%0d busy after", v), int'(busy), 0);
        end
        checkOutput("table row_count", int'(row_count), 6);
        checkOutput("table overflow", int'(overflow), 0);

        for (int l = 0; l < 4; l++) begin
            applyStimulus(4'(1 << l), pack4(1, 2, 3, 4), 4'd0, 1'b0);
            step();
            valid_in = 4'b0000;
            if (l < 3) begin
                checkOutput($sformatf("skew partial%0d out_valid", l), int'(out_valid), 0);
                checkOutput($sformatf("skew partial%0d busy", l), int'(busy), 1);
            end
        end
        drainRow(exp4(1, 2, 3, 4), "skew");
        checkOutput("skew single row", int'(out_valid), 0);
        checkOutput("skew row_count", int'(row_count), 7);

        applyStimulus(4'b0001, pack4(11, 0, 0, 0), 4'd0, 1'b0);
        step();
        applyStimulus(4'b0001, pack4(22, 0, 0, 0), 4'd0, 1'b0);
        step();
        checkOutput("recapture overflow", int'(overflow), 1);
        checkOutput("recapture no row yet", int'(out_valid), 0);
        applyStimulus(4'b1110, pack4(0, 33, 44, 55), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        drainRow(exp4(22, 33, 44, 55), "recap");

        applyStimulus(4'b1111, pack4(1, 2, 3, 4), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        step();
        step();
        checkOutput("clear pre lane", int'(out_lane), 2);
        clear    = 1'b1;
        valid_in = 4'b1111;
        step();
        clear    = 1'b0;
        valid_in = 4'b0000;
        checkOutput("clear out_valid", int'(out_valid), 0);
        checkOutput("clear row_count", int'(row_count), 0);
        checkOutput("clear overflow", int'(overflow), 0);
        checkOutput("clear busy", int'(busy), 0);
        checkOutput("clear out_lane", int'(out_lane), 0);
        applyStimulus(4'b1111, pack4(5, 6, 7, 8), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        drainRow(exp4(5, 6, 7, 8), "postclear");
        checkOutput("postclear row_count", int'(row_count), 1);

        applyStimulus(4'b1111, pack4(9, 10, 11, 12), 4'd0, 1'b0);
        step();
        applyStimulus(4'b0011, pack4(70, 71, 0, 0), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        checkOutput("prereset lane", int'(out_lane), 1);
        rst = 1'b0;
        #1;
        checkOutput("async reset out_valid", int'(out_valid), 0);
        checkOutput("async reset busy", int'(busy), 0);
        checkOutput("async reset row_count", int'(row_count), 0);
        step();
        checkOutput("reset held out_valid", int'(out_valid), 0);
        checkOutput("reset held overflow", int'(overflow), 0);
        rst = 1'b1;
        step();
        applyStimulus(4'b1100, pack4(0, 0, 30, 40), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        checkOutput("no partial survives", int'(out_valid), 0);
        applyStimulus(4'b0011, pack4(10, 20, 0, 0), 4'd0, 1'b0);
        step();
        valid_in = 4'b0000;
        drainRow(exp4(10, 20, 30, 40), "postreset");
        checkOutput("postreset row_count", int'(row_count), 1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clear2 row_count", int'(row_count), 0);

        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            applyStimulus(4'b1111, pack4(r*10, r*10+1, r*10+2, r*10+3), 4'd0, 1'b0);
            step();
            if (r == 3) begin
                checkOutput("bp full no overflow", int'(overflow), 0);
            end
        end
        valid_in = 4'b0000;
        checkOutput("bp overflow", int'(overflow), 1);
        checkOutput("bp out_valid", int'(out_valid), 1);
        step();
        checkOutput("bp stall lane", int'(out_lane), 0);
        checkOutput("bp stall data", int'(out_data), 0);
        checkOutput("bp stall last", int'(out_last), 0);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            drainRow(exp4(r*10, r*10+1, r*10+2, r*10+3), $sformatf("bp row%0d", r));
        end
        checkOutput("bp drained", int'(out_valid), 0);
        checkOutput("bp row_count", int'(row_count), 4);
        checkOutput("bp busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
